// File: rtl/store_pkg.sv
// Shared encodings for the read-modify-write store path.
// Store sizes, FSM state type and the legality rule.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    ERR
  } state_e;

  function automatic logic is_legal(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: ok = 1'b1;
      size == SZ_HALF: ok = !off[0];
      size == SZ_WORD: ok = (off == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Inserts a right-aligned store value into the addressed lanes
// of an existing word; untouched lanes keep the old data.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    unique case (1'b1)
      size == SZ_BYTE:
        merged[{offset, 3'b000} +: 8] = data[7:0];
      size == SZ_HALF:
        merged[{offset[1], 4'b0000} +: 16] = data[15:0];
      size == SZ_WORD:
        merged = data;
      default:
        merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_ram.sv
// Sub-word store unit over a word-only RAM: read, merge lanes,
// write back. Word stores skip the read; misaligned ones abort.
module store_merge_ram
  import store_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_store_req,
  input  logic [1:0]        i_store_size,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_store_data,
  input  logic [31:0]       i_ram_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [31:0]       o_ram_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_misaligned
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged;
  logic              accept;

  // Byte-address bits above the RAM word range are don't-care.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

  assign accept = (state_q == IDLE) && i_store_req;

  byte_lane_merge u_merge (
    .old_word (i_ram_rdata),
    .data     (data_q),
    .size     (size_q),
    .offset   (off_q),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_store_req) begin
          if (!is_legal(i_store_size, i_addr[1:0]))
            state_d = ERR;
          else if (i_store_size == SZ_WORD)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ:    state_d = MERGE;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= i_addr[ADDR_W+1:2];
        off_q   <= i_addr[1:0];
        size_q  <= i_store_size;
        data_q  <= i_store_data;
        // A word store writes its data as-is.
        wdata_q <= i_store_data;
      end else if (state_q == MERGE) begin
        wdata_q <= merged;
      end
    end
  end

  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == WRITE);
  assign o_ram_we     = (state_q == WRITE);
  assign o_misaligned = (state_q == ERR);
  assign o_ram_addr   = addr_q;
  assign o_ram_wdata  = o_ram_we ? wdata_q : 32'h0;

endmodule

// File: tb/tb_store_merge_ram.sv
// Directed bench for store_merge_ram with a behavioural word RAM,
// a vector table and hand-written reset / busy sequences.
module tb_store_merge_ram;

  localparam int ADDR_W = 8;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] init;
    int          lat;
    logic        err;
    logic [7:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [31:0]       data;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic              busy;
  logic              done;
  logic              mis;

  logic [31:0] mem [256];
  int          nwr;
  int          n_chk;
  int          n_fail;
  vec_t        vecs[14];

  store_merge_ram #(.ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_store_req  (req),
    .i_store_size (size),
    .i_addr       (addr),
    .i_store_data (data),
    .i_ram_rdata  (rdata),
    .o_ram_addr   (ram_addr),
    .o_ram_we     (ram_we),
    .o_ram_wdata  (ram_wdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_misaligned (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read word RAM model.
  always @(posedge clk) begin
    rdata <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] = ram_wdata;
      nwr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
    input logic [31:0] i, input int l, input logic e,
    input logic [7:0] wa, input logic [31:0] wd);
    vec_t v;
    v.size = s; v.addr = a; v.data = d; v.init = i;
    v.lat = l; v.err = e; v.waddr = wa; v.wdata = wd;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " addr"},  32'(ram_addr), 32'h0);
    check({tag, " we"},    32'(ram_we), 32'h0);
    check({tag, " wdata"}, ram_wdata, 32'h0);
    check({tag, " done"},  32'(done), 32'h0);
    check({tag, " mis"},   32'(mis), 32'h0);
    check({tag, " busy"},  32'(busy), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          wr0;
    int          cyc;
    logic        hit;
    logic        m;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    string       t;
    t = $sformatf("v%0d", idx);
    mem[v.addr[9:2]] = v.init;
    wr0 = nwr;
    hit = 1'b0; m = 1'b0; we = 1'b0; wa = '0; wd = '0;
    @(negedge clk);
    req = 1'b1; size = v.size; addr = v.addr; data = v.data;
    @(posedge clk); #1;
    req = 1'b0; addr = 32'h0; data = 32'h0;
    cyc = 1;
    while (!hit && cyc <= 6) begin
      if (done || mis) begin
        hit = 1'b1; m = mis; we = ram_we;
        wa = ram_addr; wd = ram_wdata;
      end else begin
        check({t, " pre we"}, 32'(ram_we), 32'h0);
        check({t, " pre addr"}, 32'(ram_addr), 32'(v.waddr));
        cyc++;
        @(posedge clk); #1;
      end
    end
    check({t, " latency"}, hit ? cyc : 0, v.lat);
    check({t, " misaligned"}, 32'(m), 32'(v.err));
    check({t, " we"}, 32'(we), 32'(!v.err));
    if (!v.err) begin
      check({t, " waddr"}, 32'(wa), 32'(v.waddr));
      check({t, " wdata"}, wd, v.wdata);
    end
    @(posedge clk); #1;
    check({t, " idle"}, 32'(busy), 32'h0);
    check({t, " ram"}, mem[v.addr[9:2]], v.err ? v.init : v.wdata);
    check({t, " writes"}, nwr - wr0, v.err ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int ndone;
    int c1, c2;
    logic [7:0]  a1, a2;
    logic [31:0] w1, w2;

    n_chk = 0; n_fail = 0; nwr = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req = 1'b0; size = 2'b00;
    addr = 32'h0; data = 32'h0;

    vecs[0]  = mk(2'b00, 32'h16, 32'h000000AB, 32'h11223344, 3, 0, 8'd5, 32'h11AB3344);
    vecs[1]  = mk(2'b01, 32'h0A, 32'h00001234, 32'hAABBCCDD, 3, 0, 8'd2, 32'h1234CCDD);
    vecs[2]  = mk(2'b10, 32'h20, 32'hDEADBEEF, 32'h00000000, 1, 0, 8'd8, 32'hDEADBEEF);
    vecs[3]  = mk(2'b01, 32'h03, 32'h00005555, 32'h600DF00D, 1, 1, 8'd0, 32'h0);
    vecs[4]  = mk(2'b10, 32'h06, 32'h12345678, 32'h0BADCAFE, 1, 1, 8'd1, 32'h0);
    vecs[5]  = mk(2'b11, 32'h10, 32'hFFFFFFFF, 32'h13579BDF, 1, 1, 8'd4, 32'h0);
    vecs[6]  = mk(2'b00, 32'h0C, 32'hFFFFFF5A, 32'h01020304, 3, 0, 8'd3, 32'h0102035A);
    vecs[7]  = mk(2'b00, 32'h0F, 32'h00000077, 32'h01020304, 3, 0, 8'd3, 32'h77020304);
    vecs[8]  = mk(2'b00, 32'h0D, 32'h00000099, 32'hCAFEBABE, 3, 0, 8'd3, 32'hCAFE99BE);
    vecs[9]  = mk(2'b01, 32'h30, 32'hABCD5678, 32'hFFFFFFFF, 3, 0, 8'd12, 32'hFFFF5678);
    vecs[10] = mk(2'b01, 32'h01, 32'h00000001, 32'h2468ACE0, 1, 1, 8'd0, 32'h0);
    vecs[11] = mk(2'b00, 32'h3FF, 32'h00000042, 32'h00000000, 3, 0, 8'd255, 32'h42000000);
    vecs[12] = mk(2'b10, 32'hFFFF0010, 32'h0F0F0F0F, 32'h12345678, 1, 0, 8'd4, 32'h0F0F0F0F);
    vecs[13] = mk(2'b01, 32'h42, 32'hFFFF8001, 32'h11111111, 3, 0, 8'd16, 32'h80011111);

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset during MERGE of a byte store.
    mem[5] = 32'h11223344;
    wr0 = nwr;
    @(negedge clk);
    req = 1'b1; size = 2'b00; addr = 32'h16; data = 32'hAB;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("rst merge busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst mid");
    repeat (2) @(posedge clk);
    #1;
    check("rst ram", mem[5], 32'h11223344);
    check("rst writes", nwr - wr0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], 100);

    // Request held high while busy; data/addr change under it.
    mem[5] = 32'h11223344;
    mem[3] = 32'h01020304;
    wr0 = nwr; ndone = 0;
    c1 = 0; c2 = 0; a1 = '0; a2 = '0; w1 = '0; w2 = '0;
    @(negedge clk);
    req = 1'b1; size = 2'b00; addr = 32'h16; data = 32'hAB;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          c1 = cyc; a1 = ram_addr; w1 = ram_wdata;
        end else begin
          c2 = cyc; a2 = ram_addr; w2 = ram_wdata;
        end
      end
      if (cyc == 4) check("b2b idle", 32'(busy), 32'h0);
      case (cyc)
        1: data = 32'hE1;
        2: begin data = 32'hE2; addr = 32'h0C; end
        3: data = 32'hE3;
        4: begin data = 32'h5A; addr = 32'h0C; end
        5: req = 1'b0;
        default: ;
      endcase
      @(posedge clk); #1;
    end
    check("b2b ndone", ndone, 2);
    check("b2b c1", c1, 3);
    check("b2b a1", 32'(a1), 32'd5);
    check("b2b w1", w1, 32'h11AB3344);
    check("b2b c2", c2, 7);
    check("b2b a2", 32'(a2), 32'd3);
    check("b2b w2", w2, 32'h0102035A);
    check("b2b writes", nwr - wr0, 2);
    check("b2b ram5", mem[5], 32'h11AB3344);
    check("b2b ram3", mem[3], 32'h0102035A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
